// File: rtl/nand_exhaustive_checker.sv
// Exhaustive stimulus/response checker for a single NAND cell: sweeps {a,b} through
// 00,01,10,11 for PASSES sweeps, samples y after a settle window and records mismatches.
module nand_exhaustive_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
);

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          vec_q, vec_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PASS_W-1:0]   pcnt_q, pcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                fv_q, fv_d;
    logic [1:0]          fvec_q, fvec_d;
    logic                exp_y;
    logic                mismatch;
    logic                last_vec;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fv_d     = fv_q;
        fvec_d   = fvec_q;
        exp_y    = ~(vec_q[1] & vec_q[0]);
        // Case inequality so that x/z on y is treated as a failure, not a match.
        mismatch = (dut_y !== exp_y);
        last_vec = (vec_q == 2'b11) && (pcnt_q == PASS_LAST);

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = 2'b00;
                    vec_d   = 2'b00;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (last_vec) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = !(fv_q || mismatch);
                    state_d = IDLE;
                end else begin
                    vec_d = vec_q + 2'b01;
                    if (vec_q == 2'b11) begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 2'b00;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
        end
    end

    assign dut_a      = vec_q[1];
    assign dut_b      = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_nand_exhaustive_checker.sv
// Bench for nand_exhaustive_checker: a behavioural NAND model with selectable faults
// feeds dut_y; run results are queued at start and compared when done pulses.
module tb_nand_exhaustive_checker;

    localparam int S     = 2;
    localparam int P     = 1;
    localparam int LAT   = 4 * P * (S + 1);
    localparam int LAT5  = 4 * 5 * (S + 1);
    localparam int BUDGET = 200;

    typedef enum int {M_GOOD, M_STUCK1, M_INV, M_FLOAT} mode_e;

    typedef struct {
        mode_e      mode;
        bit         repulse;
        logic [3:0] err;
        logic       fv;
        logic [1:0] vec;
        logic       pass;
    } run_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dut_a, dut_b, dut_y, busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [1:0] fail_vec;

    logic       start5 = 1'b0;
    logic       dut_a5, dut_b5, dut_y5, busy5, done5, pass5, fail_valid5;
    logic [3:0] err_count5;
    logic [1:0] fail_vec5;

    mode_e      mode = M_GOOD;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic model_y(mode_e m, logic a, logic b);
        logic y;
        case (m)
            M_GOOD:   y = ~(a & b);
            M_STUCK1: y = 1'b1;
            M_INV:    y = a & b;
            default:  y = 1'bz;
        endcase
        return y;
    endfunction

    always_comb dut_y = model_y(mode, dut_a, dut_b);
    assign dut_y5 = dut_a5 & dut_b5;

    nand_exhaustive_checker #(.SETTLE_CYCLES(S), .PASSES(P), .ERR_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    nand_exhaustive_checker #(.SETTLE_CYCLES(S), .PASSES(5), .ERR_W(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5),
        .dut_a(dut_a5), .dut_b(dut_b5), .dut_y(dut_y5),
        .busy(busy5), .done(done5), .pass(pass5), .err_count(err_count5),
        .fail_valid(fail_valid5), .fail_vec(fail_vec5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Packs {pass, fail_valid, fail_vec, err_count, latency}.
    function automatic logic [15:0] pack_exp(logic p, logic fv, logic [1:0] v, logic [3:0] e, int lat);
        return {p, fv, v, e, 8'(lat)};
    endfunction

    task automatic check_result(input string tag, input int done_at, input logic [15:0] e,
                                input logic p, input logic fv, input logic [1:0] v,
                                input logic [3:0] err, input logic b);
        check({tag, "_latency"},    32'(done_at), 32'(e[7:0]));
        check({tag, "_err_count"},  32'(err),     32'(e[11:8]));
        check({tag, "_fail_vec"},   32'(v),       32'(e[13:12]));
        check({tag, "_fail_valid"}, 32'(fv),      32'(e[14]));
        check({tag, "_pass"},       32'(p),       32'(e[15]));
        check({tag, "_busy_end"},   32'(b),       32'd0);
    endtask

    // Called at a negedge; returns at the negedge following the done edge.
    task automatic run(input mode_e m, input bit repulse, input logic [15:0] e);
        int done_at;
        logic [15:0] got;
        mode = m;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        check("accept_err_clear", 32'(err_count), 32'd0);
        check("accept_fv_clear", 32'(fail_valid), 32'd0);
        check("accept_vec", 32'({dut_a, dut_b}), 32'd0);
        done_at = -1;
        for (int k = 1; k <= BUDGET && done_at < 0; k++) begin
            if (repulse && k == 5) start = 1'b1;
            @(negedge clk);
            if (repulse && k == 5) start = 1'b0;
            if (done) begin
                done_at = k;
            end else if (k < LAT) begin
                check("vector", 32'({dut_a, dut_b}), 32'(k / (S + 1)));
            end
        end
        if (done_at < 0) check("done_timeout", 32'd0, 32'd1);
        got = exp_q.pop_front();
        check_result("run", done_at, got, pass, fail_valid, fail_vec, err_count, busy);
        check("final_vec_held", 32'({dut_a, dut_b}), 32'd3);
    endtask

    run_t        runs[4];
    logic [3:0]  fe;
    logic        ff;
    logic [1:0]  fvv;
    logic [1:0]  vv;
    logic        saw_done;
    int          done_at5;

    initial begin
        runs[0] = '{M_GOOD,   1'b0, 4'd0, 1'b0, 2'b00, 1'b1};
        runs[1] = '{M_STUCK1, 1'b0, 4'd1, 1'b1, 2'b11, 1'b0};
        runs[2] = '{M_INV,    1'b0, 4'd4, 1'b1, 2'b00, 1'b0};
        runs[3] = '{M_GOOD,   1'b1, 4'd0, 1'b0, 2'b00, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({busy, done, pass, err_count, fail_valid, fail_vec, dut_a, dut_b}), 32'd0);
        check("rst_outputs5", 32'({busy5, done5, pass5, err_count5, fail_valid5, fail_vec5, dut_a5, dut_b5}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run(runs[i].mode, runs[i].repulse,
                pack_exp(runs[i].pass, runs[i].fv, runs[i].vec, runs[i].err, LAT));
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("pass_hold", 32'(pass), 32'(runs[i].pass));
            check("err_hold", 32'(err_count), 32'(runs[i].err));
        end

        // Floating y: expectation follows whatever value the model's z resolves to.
        fe = 4'd0; ff = 1'b0; fvv = 2'b00;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (model_y(M_FLOAT, vv[1], vv[0]) !== ~(vv[1] & vv[0])) begin
                fe = fe + 4'd1;
                if (!ff) begin
                    ff  = 1'b1;
                    fvv = vv;
                end
            end
        end
        @(negedge clk);
        run(M_FLOAT, 1'b0, pack_exp(!ff, ff, fvv, fe, LAT));
        // Restart on the edge right after done.
        run(M_GOOD, 1'b0, pack_exp(1'b1, 1'b0, 2'b00, 4'd0, LAT));

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_outputs", 32'({busy, done, pass, err_count, fail_valid, fail_vec, dut_a, dut_b}), 32'd0);
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_rst", 32'(saw_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run(M_GOOD, 1'b0, pack_exp(1'b1, 1'b0, 2'b00, 4'd0, LAT));

        // Five sweeps against an AND cell: 20 mismatches saturate the counter.
        @(negedge clk);
        start5 = 1'b1;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 2'b00, 4'd15, LAT5));
        @(negedge clk);
        start5 = 1'b0;
        check("p5_accept_busy", 32'(busy5), 32'd1);
        done_at5 = -1;
        for (int k = 1; k <= BUDGET && done_at5 < 0; k++) begin
            @(negedge clk);
            if (done5) done_at5 = k;
        end
        if (done_at5 < 0) check("p5_done_timeout", 32'd0, 32'd1);
        check_result("p5", done_at5, exp_q.pop_front(), pass5, fail_valid5, fail_vec5, err_count5, busy5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nand_exhaustive_checker.md
Name: nand_exhaustive_checker

Overview:
Self-checking stimulus/response stage wrapped around the switch-level NAND cell. On a start pulse it drives the NAND's a/b inputs through all four input combinations, waits a programmable settle time, samples y and compares it against the ideal NAND value. It reports busy/done, pass/fail, a saturating error count and the first failing vector. It sits directly upstream of the cell, feeding a/b, and directly downstream of it, consuming y.

Parameters:
SETTLE_CYCLES, 2, clocks to hold each vector before sampling y; legal range >=1
PASSES, 1, number of full 4-vector sweeps per run; legal range >=1
ERR_W, 4, width of err_count

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled on rising clk edge
dut_a  output  1  drives NAND input a
dut_b  output  1  drives NAND input b
dut_y  input  1  NAND output y
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at end of run
pass  output  1  result of the last completed run (1 = zero mismatches)
err_count  output  ERR_W  mismatches in the current/last run, saturating
fail_valid  output  1  at least one mismatch recorded this run
fail_vec  output  2  {a,b} of the first mismatching vector

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; internal vector index, settle counter and pass counter cleared. Reset mid-run aborts immediately; no done pulse follows.
- States: IDLE, SETTLE, SAMPLE.
- IDLE: on an edge with start=1: busy<=1, done<=0, pass<=0, err_count<=0, fail_valid<=0, fail_vec<=0, vector index<=0, {dut_a,dut_b}<=2'b00, settle counter<=0, pass counter<=0, go to SETTLE. start=0: hold; done returns to 0 one cycle after being pulsed.
- SETTLE: each edge, if counter==SETTLE_CYCLES-1 go to SAMPLE, else counter+1. dut_a/dut_b held stable for the whole SETTLE+SAMPLE window.
- SAMPLE (one edge): expected = ~(dut_a & dut_b). Mismatch when dut_y !== expected; x or z on dut_y counts as a mismatch. On mismatch: err_count+1, saturating at 2^ERR_W-1; if fail_valid==0, set fail_valid<=1 and fail_vec<={dut_a,dut_b}.
  - Not the final vector: index+1 (order 00, 01, 10, 11; after 11 wrap to 00 and increment the pass counter), drive the new vector, counter<=0, go to SETTLE.
  - Final vector (11 of pass PASSES-1): busy<=0, done<=1, pass<=(no mismatch this run, including this sample), go to IDLE. dut_a/dut_b keep 2'b11.
- Latency: each vector occupies SETTLE_CYCLES+1 clocks. The start-accept edge to the done-assert edge spans 4*PASSES*(SETTLE_CYCLES+1) clocks (12 at defaults).
- start while busy=1: ignored, with no restart and no error.
- start=1 on the edge after done asserts (state IDLE, done high): accepted; done drops and a new run begins with cleared results.
- pass, err_count, fail_valid and fail_vec hold after done until the next accepted start or reset.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Good DUT (real NAND cell), defaults, start pulse -> dut_a/dut_b step 00,01,10,11 at 3-cycle spacing; done pulses exactly 12 clocks after the accept edge; pass=1, err_count=0, fail_valid=0.
- Stuck-at-1 model on dut_y -> one mismatch at vector 11; err_count=1, fail_vec=2'b11, fail_valid=1, pass=0.
- Inverted model (y = a&b), PASSES=5, ERR_W=4 -> 20 mismatches, err_count saturates at 15, fail_vec=2'b00, pass=0, done 60 clocks after accept.
- dut_y floating (z) -> 4 mismatches, err_count=4, pass=0. Then connect a good DUT, assert start on the cycle after done -> done drops, results clear, second run ends with pass=1.
- start re-pulsed at cycle 5 of a run -> ignored; sequence and done timing unchanged (done at clock 12).
- rst_n low at cycle 7 mid-run -> all outputs 0 immediately, with no done pulse. After rst_n is released and start is asserted, the run completes normally with pass=1.
